// File: rtl/l1_mem_arbiter.sv
// rtl/l1_mem_arbiter.sv - shares the memory block port between I-cache and D-cache miss traffic
// Define L1_MEM_ARB_RR_EN for round-robin ties; default build is fixed D-over-I priority.
module l1_mem_arbiter #(
  parameter int ADDR_BITS  = 26,
  parameter int BLOCK_BITS = 128
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  iMemRen,
  input  logic [ADDR_BITS-1:0]  iBlockAddr,
  output logic                  iMemReadReady,
  output logic [BLOCK_BITS-1:0] iMemDout,
  input  logic                  dMemRen,
  input  logic                  dMemWen,
  input  logic [ADDR_BITS-1:0]  dBlockAddr,
  input  logic [BLOCK_BITS-1:0] dMemDin,
  output logic                  dMemReadReady,
  output logic                  dMemWriteDone,
  output logic [BLOCK_BITS-1:0] dMemDout,
  output logic                  memRen,
  output logic                  memWen,
  output logic [ADDR_BITS-1:0]  memBlockAddr,
  output logic [BLOCK_BITS-1:0] memDin,
  input  logic                  memReadReady,
  input  logic                  memWriteDone,
  input  logic [BLOCK_BITS-1:0] memDout
);

  typedef enum logic [2:0] {IDLE, I_RD, D_RD, D_WR, RELEASE} state_t;

  state_t state;
  logic   lock;
  logic   d_req;
  logic   d_tie;
  logic   d_wins;

`ifdef L1_MEM_ARB_RR_EN
  logic   i_first;
  assign d_tie = ~i_first;
`else
  assign d_tie = 1'b1;
`endif

  assign d_req  = dMemRen | dMemWen;
  // lock keeps a writeback and its refill back to back ahead of a waiting I miss
  assign d_wins = d_req & (lock | ~iMemRen | d_tie);

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      lock  <= 1'b0;
`ifdef L1_MEM_ARB_RR_EN
      i_first <= 1'b1;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (d_wins) begin
            state <= dMemWen ? D_WR : D_RD;
`ifdef L1_MEM_ARB_RR_EN
            i_first <= 1'b1;
`endif
          end else if (iMemRen) begin
            state <= I_RD;
`ifdef L1_MEM_ARB_RR_EN
            i_first <= 1'b0;
`endif
          end
          if (!d_req) lock <= 1'b0;
        end
        I_RD: begin
          if (!iMemRen || memReadReady) state <= RELEASE;
        end
        D_RD: begin
          if (!dMemRen) begin
            state <= RELEASE;
          end else if (memReadReady) begin
            state <= RELEASE;
            lock  <= 1'b0;
          end
        end
        D_WR: begin
          if (!dMemWen) begin
            state <= RELEASE;
          end else if (memWriteDone) begin
            state <= RELEASE;
            lock  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    memRen        = 1'b0;
    memWen        = 1'b0;
    memBlockAddr  = '0;
    memDin        = '0;
    iMemReadReady = 1'b0;
    iMemDout      = '0;
    dMemReadReady = 1'b0;
    dMemWriteDone = 1'b0;
    dMemDout      = '0;
    case (state)
      I_RD: begin
        memRen       = 1'b1;
        memBlockAddr = iBlockAddr;
        if (iMemRen && memReadReady) begin
          iMemReadReady = 1'b1;
          iMemDout      = memDout;
        end
      end
      D_RD: begin
        memRen       = 1'b1;
        memBlockAddr = dBlockAddr;
        if (dMemRen && memReadReady) begin
          dMemReadReady = 1'b1;
          dMemDout      = memDout;
        end
      end
      D_WR: begin
        memWen       = 1'b1;
        memBlockAddr = dBlockAddr;
        memDin       = dMemDin;
        if (dMemWen && memWriteDone) dMemWriteDone = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_l1_mem_arbiter.sv
// tb/tb_l1_mem_arbiter.sv - bench for l1_mem_arbiter (scripted vectors plus randomized reference model)
module tb_l1_mem_arbiter;
  localparam int AB = 26;
  localparam int BB = 128;
`ifdef L1_MEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset;
  logic          iMemRen, dMemRen, dMemWen;
  logic [AB-1:0] iBlockAddr, dBlockAddr, memBlockAddr;
  logic [BB-1:0] dMemDin, memDout, iMemDout, dMemDout, memDin;
  logic          iMemReadReady, dMemReadReady, dMemWriteDone;
  logic          memRen, memWen, memReadReady, memWriteDone;

  always #5 clock = ~clock;

  l1_mem_arbiter #(.ADDR_BITS(AB), .BLOCK_BITS(BB)) dut (
    .clock(clock), .reset(reset),
    .iMemRen(iMemRen), .iBlockAddr(iBlockAddr),
    .iMemReadReady(iMemReadReady), .iMemDout(iMemDout),
    .dMemRen(dMemRen), .dMemWen(dMemWen), .dBlockAddr(dBlockAddr), .dMemDin(dMemDin),
    .dMemReadReady(dMemReadReady), .dMemWriteDone(dMemWriteDone), .dMemDout(dMemDout),
    .memRen(memRen), .memWen(memWen), .memBlockAddr(memBlockAddr), .memDin(memDin),
    .memReadReady(memReadReady), .memWriteDone(memWriteDone), .memDout(memDout)
  );

  typedef logic [5+AB+3*BB-1:0] ovec_t;

  function automatic ovec_t pack(input logic ren, wen, pi, pd, pw, input logic [AB-1:0] addr,
                                 input logic [BB-1:0] din, idout, ddout);
    return {ren, wen, pi, pd, pw, addr, din, idout, ddout};
  endfunction

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input ovec_t exp);
    ovec_t act;
    act = pack(memRen, memWen, iMemReadReady, dMemReadReady, dMemWriteDone,
               memBlockAddr, memDin, iMemDout, dMemDout);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  typedef struct {
    logic rst, ir, dr, dw, rr, wd;
    logic ren, wen, pi, pd, pw;
    int   sel;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input logic rst, ir, dr, dw, rr, wd, ren, wen, pi, pd, pw, input int sel);
    vec_t v;
    v.rst = rst; v.ir = ir; v.dr = dr; v.dw = dw; v.rr = rr; v.wd = wd;
    v.ren = ren; v.wen = wen; v.pi = pi; v.pd = pd; v.pw = pw; v.sel = sel;
    tbl.push_back(v);
  endtask

  // reference model: who owns the port, and whether a turnaround cycle is pending
  int   owner;
  bit   in_release, m_lock, m_i_first;

  function automatic ovec_t model_out();
    logic ren, wen, pi, pd, pw;
    logic [AB-1:0] addr;
    ren  = (owner == 1) || (owner == 2);
    wen  = (owner == 3);
    addr = (owner == 1) ? iBlockAddr : (owner >= 2) ? dBlockAddr : '0;
    pi   = (owner == 1) && iMemRen && memReadReady;
    pd   = (owner == 2) && dMemRen && memReadReady;
    pw   = (owner == 3) && dMemWen && memWriteDone;
    return pack(ren, wen, pi, pd, pw, addr, wen ? dMemDin : '0,
                pi ? memDout : '0, pd ? memDout : '0);
  endfunction

  task automatic model_step();
    bit dreq, d_first;
    if (reset) begin
      owner = 0; in_release = 0; m_lock = 0; m_i_first = 1;
    end else if (in_release) begin
      in_release = 0;
    end else if (owner == 0) begin
      dreq    = dMemRen || dMemWen;
      d_first = m_lock || !iMemRen || (RR ? !m_i_first : 1'b1);
      if (dreq && d_first) begin
        owner = dMemWen ? 3 : 2;
        m_i_first = 1;
      end else if (iMemRen) begin
        owner = 1;
        m_i_first = 0;
      end
      if (!dreq) m_lock = 0;
    end else begin
      case (owner)
        1: if (!iMemRen || memReadReady) begin owner = 0; in_release = 1; end
        2: if (!dMemRen) begin owner = 0; in_release = 1; end
           else if (memReadReady) begin owner = 0; in_release = 1; m_lock = 0; end
        default: if (!dMemWen) begin owner = 0; in_release = 1; end
                 else if (memWriteDone) begin owner = 0; in_release = 1; m_lock = 1; end
      endcase
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [AB-1:0] ia, da, sa;
    logic [BB-1:0] dd, md;
    bit fi;
    ia = 26'h0012340;
    da = 26'h0000003;
    dd = {16{8'hA5}};
    md = {4{32'hDEADBEEF}};
    fi = RR;

    // single I read, five-cycle memory latency
    add(1,1,1,1,0,0, 0,0,0,0,0, 0);
    add(0,1,0,0,0,0, 0,0,0,0,0, 0);
    for (int k = 0; k < 5; k++) add(0,1,0,0,0,0, 1,0,0,0,0, 1);
    add(0,1,0,0,1,0, 1,0,1,0,0, 1);
    add(0,0,0,0,0,0, 0,0,0,0,0, 0);
    add(0,0,0,0,0,0, 0,0,0,0,0, 0);
    // simultaneous I/D reads right after reset
    add(1,1,1,0,0,0, 0,0,0,0,0, 0);
    add(0,1,1,0,0,0, 0,0,0,0,0, 0);
    add(0,1,1,0,0,0, 1,0,0,0,0, fi ? 1 : 2);
    add(0,1,1,0,1,0, 1,0,fi,!fi,0, fi ? 1 : 2);
    add(0,!fi,fi,0,0,0, 0,0,0,0,0, 0);
    add(0,!fi,fi,0,0,0, 0,0,0,0,0, 0);
    add(0,!fi,fi,0,0,0, 1,0,0,0,0, fi ? 2 : 1);
    add(0,!fi,fi,0,1,0, 1,0,!fi,fi,0, fi ? 2 : 1);
    add(0,0,0,0,0,0, 0,0,0,0,0, 0);
    add(0,0,0,0,1,1, 0,0,0,0,0, 0);
    // writeback, then refill kept ahead of a pending I read
    add(0,0,0,1,0,0, 0,0,0,0,0, 0);
    add(0,1,0,1,0,0, 0,1,0,0,0, 2);
    add(0,1,0,1,1,0, 0,1,0,0,0, 2);
    add(0,1,0,1,0,1, 0,1,0,0,1, 2);
    add(0,1,1,0,0,0, 0,0,0,0,0, 0);
    add(0,1,1,0,0,0, 0,0,0,0,0, 0);
    add(0,1,1,0,0,0, 1,0,0,0,0, 2);
    add(0,1,1,0,0,1, 1,0,0,0,0, 2);
    add(0,1,1,0,1,0, 1,0,0,1,0, 2);
    add(0,1,0,0,0,0, 0,0,0,0,0, 0);
    add(0,1,0,0,0,0, 0,0,0,0,0, 0);
    add(0,1,0,0,0,0, 1,0,0,0,0, 1);
    add(0,1,0,0,1,0, 1,0,1,0,0, 1);
    add(0,0,0,0,0,0, 0,0,0,0,0, 0);
    add(0,0,0,0,0,0, 0,0,0,0,0, 0);
    // D read aborted two cycles in
    add(0,0,1,0,0,0, 0,0,0,0,0, 0);
    add(0,0,1,0,0,0, 1,0,0,0,0, 2);
    add(0,0,1,0,0,0, 1,0,0,0,0, 2);
    add(0,0,0,0,0,0, 1,0,0,0,0, 2);
    add(0,0,0,0,1,0, 0,0,0,0,0, 0);
    add(0,0,0,0,0,0, 0,0,0,0,0, 0);
    // reset during a writeback
    add(0,0,0,1,0,0, 0,0,0,0,0, 0);
    add(0,0,0,1,0,0, 0,1,0,0,0, 2);
    add(1,0,0,1,0,0, 0,1,0,0,0, 2);
    add(0,0,0,1,0,1, 0,0,0,0,0, 0);
    add(0,0,0,1,0,0, 0,1,0,0,0, 2);
    add(0,0,0,0,0,0, 0,1,0,0,0, 2);
    add(0,0,0,0,0,1, 0,0,0,0,0, 0);
    add(0,0,0,0,0,0, 0,0,0,0,0, 0);

    reset = 1'b1;
    iMemRen = 0; dMemRen = 0; dMemWen = 0; memReadReady = 0; memWriteDone = 0;
    iBlockAddr = ia; dBlockAddr = da; dMemDin = dd; memDout = md;
    repeat (2) @(posedge clock);

    foreach (tbl[i]) begin
      @(negedge clock);
      reset = tbl[i].rst; iMemRen = tbl[i].ir; dMemRen = tbl[i].dr; dMemWen = tbl[i].dw;
      memReadReady = tbl[i].rr; memWriteDone = tbl[i].wd;
      #1;
      sa = (tbl[i].sel == 1) ? ia : (tbl[i].sel == 2) ? da : '0;
      check($sformatf("vec%0d", i),
            pack(tbl[i].ren, tbl[i].wen, tbl[i].pi, tbl[i].pd, tbl[i].pw, sa,
                 tbl[i].wen ? dd : '0, tbl[i].pi ? md : '0, tbl[i].pd ? md : '0));
    end

    @(negedge clock);
    reset = 1'b1; iMemRen = 0; dMemRen = 0; dMemWen = 0; memReadReady = 0; memWriteDone = 0;
    model_step();
    for (int c = 0; c < 3000; c++) begin
      @(negedge clock);
      reset = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 5) == 0) iMemRen = ~iMemRen;
      if ($urandom_range(0, 5) == 0) dMemRen = ~dMemRen;
      if ($urandom_range(0, 7) == 0) dMemWen = ~dMemWen;
      memReadReady = ($urandom_range(0, 3) == 0);
      memWriteDone = ($urandom_range(0, 3) == 0);
      iBlockAddr = AB'($urandom);
      dBlockAddr = AB'($urandom);
      dMemDin = {$urandom, $urandom, $urandom, $urandom};
      memDout = {$urandom, $urandom, $urandom, $urandom};
      #1;
      check($sformatf("rand%0d", c), model_out());
      model_step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/l1_mem_arbiter.md
# l1_mem_arbiter

Shares the single main-memory block port between the L1 I-cache controller and the D-cache controller. Each controller presents its miss traffic (block read and, for the D-side, dirty-block writeback) as level requests. The arbiter grants one requester at a time and drives the memory port. It routes `memReadReady`/`memWriteDone` and read data back only to the granted side. A D-side writeback followed by its refill is kept atomic.

## Interface
Parameters:
- `ADDR_BITS`, default 26: block-address width.
- `BLOCK_BITS`, default 128: block data width.

Ports:
- `clock`  in  1  sole clock, rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `iMemRen`  in  1  I-cache block-read request (level).
- `iBlockAddr`  in  ADDR_BITS  I-cache block address.
- `iMemReadReady`  out  1  one-cycle pulse: I read data valid.
- `iMemDout`  out  BLOCK_BITS  I read data.
- `dMemRen`  in  1  D-cache block-read request (level).
- `dMemWen`  in  1  D-cache writeback request (level).
- `dBlockAddr`  in  ADDR_BITS  D-cache block address.
- `dMemDin`  in  BLOCK_BITS  D writeback data.
- `dMemReadReady`  out  1  one-cycle pulse: D read data valid.
- `dMemWriteDone`  out  1  one-cycle pulse: D writeback complete.
- `dMemDout`  out  BLOCK_BITS  D read data.
- `memRen`, `memWen`  out  1  memory read/write strobes, held until completion.
- `memBlockAddr`  out  ADDR_BITS  memory block address.
- `memDin`  out  BLOCK_BITS  memory write data.
- `memReadReady`, `memWriteDone`  in  1  memory completion pulses.
- `memDout`  in  BLOCK_BITS  memory read data.

## Operation
- States:
  - IDLE: arbitrate.
  - I_RD: grant I read.
  - D_RD: grant D read.
  - D_WR: grant D writeback.
  - RELEASE: one-cycle turnaround.
- IDLE selection, registered into the next state:
  - D is requesting if `dMemRen|dMemWen`.
  - `dMemWen` beats `dMemRen` when both are high.
  - Arbitration policy is set by Configuration.
  - With `lock` set and D requesting, D wins unconditionally.
  - With no request, stay in IDLE.
- I_RD:
  - `memRen=1`, `memBlockAddr=iBlockAddr`.
  - On `memReadReady`: `iMemReadReady=1`, `iMemDout=memDout` combinationally in the same cycle, then RELEASE.
- D_RD: same as I_RD on the D side; clears `lock`.
- D_WR:
  - `memWen=1`, `memBlockAddr=dBlockAddr`, `memDin=dMemDin`.
  - On `memWriteDone`: `dMemWriteDone=1`, set `lock`, then RELEASE.
- RELEASE:
  - No strobes asserted; no requests sampled.
  - Goes to IDLE.
- Abort: if the granted request drops before completion, go to RELEASE with no response pulse.
- Mismatched completions are ignored and never forwarded:
  - `memWriteDone` during a read grant.
  - `memReadReady` during a write grant.
  - Any completion in IDLE or RELEASE.
- `lock` clears when a D_RD completes, or when IDLE finds no D request.
- Outputs not owned by the current grant are driven to 0 (data buses included).

## Timing
- Reset (sync, one edge): state=IDLE, `lock`=0, round-robin pointer=I-first. All outputs read 0 from the next cycle.
- Request seen in IDLE at cycle 0 → strobe asserted in cycle 1.
- Completion at cycle N → response pulse in cycle N. RELEASE at N+1. IDLE at N+2. Earliest next grant strobe at N+3.
- Reset asserted mid-grant: strobes drop after that edge. Any completion arriving afterwards is discarded.
- Writeback then refill: D_WR done at N → RELEASE → IDLE sees `dMemRen` with `lock` → D_RD strobe at N+3. A pending `iMemRen` is skipped.

## Configuration
- `L1_MEM_ARB_RR_EN` defined: round-robin.
  - The side not granted last wins ties.
  - The pointer updates on every grant, aborted ones included.
  - `lock` still overrides.
- Undefined: fixed priority, D over I. The pointer logic is absent.

## Test plan
- Reset: pulse `reset` with all requests high → after the edge all outputs 0. First grant strobe is one cycle after `reset` falls.
- Single I read: `iMemRen`, addr 0x0012340. Memory ready after 5 cycles, data 0xDEADBEEF_… → `memRen` cycles 1–6, `iMemReadReady` pulse in cycle 6 with data. `dMemReadReady` stays 0.
- Tie: `iMemRen` and `dMemRen` rise together.
  - With RR: first grant I, second grant D.
  - Without RR: D then I.
- Atomic writeback: `dMemWen` (addr 0x3, data 0xA5…) completes while `iMemRen` is pending. `dMemRen` follows → memory sees write 0x3, then read from D, then read from I.
- Abort: `dMemRen` drops 2 cycles into D_RD, memory then pulses `memReadReady` → no `dMemReadReady`, back in IDLE 2 cycles after the drop.
- Mid-op reset: `reset` during D_WR → `memWen`=0 next cycle. A later `memWriteDone` produces no `dMemWriteDone`.
